data_bus_arbiter: RTL and testbench

- Two-requester arbiter placed in front of the data-bus address decoder.
- Shares the single req/gnt/rvalid data port between the CPU load/store unit (M0) and a secondary master such as DMA or debug (M1).
- Picks a master by round-robin and holds it until the downstream grant. It tracks outstanding transactions in an owner FIFO so each rvalid/rdata/err returns to the master that issued the request.

---
 rtl/data_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master round-robin data-bus arbiter with in-order response routing
module data_bus_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  output logic            s_req,
  output logic            s_we,
  output logic [DW/8-1:0] s_be,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_gnt,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_err,
  output logic            orphan_rsp
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic            sel_owner_q, sel_owner_d;
  logic            owner_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            orphan_q;
  logic            full, push, pop, cur, cur_req, head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count_q == CW'(DEPTH));
  assign head = owner_q[rd_ptr_q];
  assign pop  = s_rvalid && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    sel_owner_d  = sel_owner_q;
    cur          = sel_owner_q;
    cur_req      = 1'b0;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        // Both requesting: pick the master that did not win last time.
        if (!full) begin
          cur     = (m0_req && m1_req) ? ~last_owner_q : m1_req;
          cur_req = m0_req || m1_req;
          if (cur_req && s_gnt) begin
            push         = 1'b1;
            last_owner_d = cur;
          end else if (cur_req) begin
            state_d     = HOLD;
            sel_owner_d = cur;
          end
        end
      end
      HOLD: begin
        cur     = sel_owner_q;
        cur_req = !full && (sel_owner_q ? m1_req : m0_req);
        if (!cur_req) begin
          state_d = IDLE;
        end else if (s_gnt) begin
          push         = 1'b1;
          last_owner_d = cur;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_req   = cur_req;
  assign s_we    = cur_req && (cur ? m1_we : m0_we);
  assign s_be    = cur_req ? (cur ? m1_be    : m0_be)    : '0;
  assign s_addr  = cur_req ? (cur ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = cur_req ? (cur ? m1_wdata : m0_wdata) : '0;
  assign m0_gnt  = push && !cur;
  assign m1_gnt  = push && cur;

  assign m0_rvalid  = pop && !head;
  assign m1_rvalid  = pop && head;
  assign m0_rdata   = m0_rvalid ? s_rdata : '0;
  assign m1_rdata   = m1_rvalid ? s_rdata : '0;
  assign m0_err     = m0_rvalid && s_err;
  assign m1_err     = m1_rvalid && s_err;
  assign orphan_rsp = orphan_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      sel_owner_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) owner_q[i] <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      sel_owner_q  <= sel_owner_d;
      if (push) begin
        owner_q[wr_ptr_q] <= cur;
        wr_ptr_q          <= ptr_next(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A response with nothing outstanding is dropped and flagged until reset.
      if (s_rvalid && (count_q == '0)) orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed self-checking bench for data_bus_arbiter
module tb_data_bus_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_gnt, s_rvalid, s_err, orphan_rsp;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int owner;

  data_bus_arbiter #(.AW(32), .DW(32), .DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .orphan_rsp(orphan_rsp)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = 32'h0;
    m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = 32'h200; m1_wdata = 32'h0;
    s_gnt = 0; s_rvalid = 0; s_rdata = 32'h0; s_err = 0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    Rst = 0;
    tick();
    Rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    #1;
    check("rst_s_req", s_req, 0);
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_orphan", orphan_rsp, 0);
    reset_dut();

    // Single M0 read: grant in cycle 0, response in cycle 1
    m0_req = 1; m0_addr = 32'h0000_1000; s_gnt = 1;
    #1;
    check("single_m0_gnt", m0_gnt, 1);
    check("single_m1_gnt", m1_gnt, 0);
    check("single_s_addr", s_addr, 32'h0000_1000);
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("single_m0_rvalid", m0_rvalid, 1);
    check("single_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("single_m1_rvalid", m1_rvalid, 0);
    check("single_m1_rdata", m1_rdata, 0);
    tick();

    // Round-robin with both masters requesting every cycle
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      m0_req = (i < 4); m1_req = (i < 4); s_gnt = (i < 4);
      s_rvalid = (i > 0); s_rdata = 32'hA000_0000 + i;
      #1;
      if (i < 4) begin
        check("rr_m0_gnt", m0_gnt, (i % 2) == 0);
        check("rr_m1_gnt", m1_gnt, (i % 2) == 1);
        check("rr_s_addr", s_addr, ((i % 2) == 0) ? 32'h100 : 32'h200);
      end
      if (i > 0) begin
        owner = (i - 1) % 2;
        check("rr_m0_rvalid", m0_rvalid, owner == 0);
        check("rr_m1_rvalid", m1_rvalid, owner == 1);
        check("rr_rdata", (owner == 1) ? m1_rdata : m0_rdata, 32'hA000_0000 + i);
      end
      tick();
    end

    // M1 held while s_gnt low; M0 cannot preempt
    reset_dut();
    m1_req = 1;
    for (int i = 0; i < 3; i++) begin
      m0_req = (i >= 1);
      #1;
      check("hold_s_req", s_req, 1);
      check("hold_s_addr", s_addr, 32'h200);
      check("hold_m0_gnt", m0_gnt, 0);
      check("hold_m1_gnt", m1_gnt, 0);
      tick();
    end
    s_gnt = 1;
    #1;
    check("hold_m1_gnt_final", m1_gnt, 1);
    check("hold_m0_gnt_final", m0_gnt, 0);
    check("hold_s_addr_final", s_addr, 32'h200);
    tick();
    m1_req = 0;
    #1;
    check("hold_next_m0_gnt", m0_gnt, 1);
    check("hold_next_s_addr", s_addr, 32'h100);
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'h11;
    #1;
    check("hold_rsp1_m1_rvalid", m1_rvalid, 1);
    check("hold_rsp1_m1_rdata", m1_rdata, 32'h11);
    check("hold_rsp1_m0_rvalid", m0_rvalid, 0);
    tick();
    s_rdata = 32'h22;
    #1;
    check("hold_rsp2_m0_rvalid", m0_rvalid, 1);
    check("hold_rsp2_m0_rdata", m0_rdata, 32'h22);
    tick();
    s_rvalid = 0;

    // Issue blocking at DEPTH outstanding, no bypass on same-cycle pop
    reset_dut();
    m0_req = 1; s_gnt = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("full_fill_gnt", m0_gnt, 1);
      tick();
    end
    #1;
    check("full_block_s_req", s_req, 0);
    check("full_block_gnt", m0_gnt, 0);
    tick();
    s_rvalid = 1; s_rdata = 32'h33;
    #1;
    check("full_pop_s_req", s_req, 0);
    check("full_pop_gnt", m0_gnt, 0);
    check("full_pop_rvalid", m0_rvalid, 1);
    tick();
    s_rvalid = 0;
    #1;
    check("full_reissue_s_req", s_req, 1);
    check("full_reissue_gnt", m0_gnt, 1);
    tick();
    m0_req = 0; s_gnt = 0; s_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("full_drain_rvalid", m0_rvalid, 1);
      tick();
    end
    s_rvalid = 0;

    // Error response routed to M1
    reset_dut();
    m1_req = 1; s_gnt = 1;
    #1;
    check("err_m1_gnt", m1_gnt, 1);
    tick();
    m1_req = 0; s_gnt = 0; s_rvalid = 1; s_err = 1;
    #1;
    check("err_m1_rvalid", m1_rvalid, 1);
    check("err_m1_err", m1_err, 1);
    check("err_m0_err", m0_err, 0);
    check("err_m0_rvalid", m0_rvalid, 0);
    tick();
    s_rvalid = 0; s_err = 0;

    // Orphan response with empty FIFO, sticky until async reset
    #1;
    check("orphan_before", orphan_rsp, 0);
    s_rvalid = 1;
    #1;
    check("orphan_m0_rvalid", m0_rvalid, 0);
    check("orphan_m1_rvalid", m1_rvalid, 0);
    tick();
    s_rvalid = 0;
    #1;
    check("orphan_set", orphan_rsp, 1);
    tick();
    check("orphan_held", orphan_rsp, 1);
    Rst = 0;
    #1;
    check("orphan_async_clear", orphan_rsp, 0);
    tick();
    Rst = 1;

    // Reset mid-transaction flushes the FIFO; late response is orphaned
    m0_req = 1; s_gnt = 1;
    #1;
    check("midrst_gnt", m0_gnt, 1);
    tick();
    clear_inputs();
    Rst = 0;
    tick();
    Rst = 1;
    s_rvalid = 1;
    #1;
    check("midrst_m0_rvalid", m0_rvalid, 0);
    tick();
    s_rvalid = 0;
    #1;
    check("midrst_orphan", orphan_rsp, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
